// File: rtl/ub_ctrl_pkg.sv
// ub_ctrl_pkg
//   Shared types and constants for the unified-buffer controller.
//   opcode_t         : instruction opcodes as carried on instr_op
//   ctrl_state_t     : controller sequencing states
//   EXT_DRAIN_CYCLES : cycles spent draining after an EXT strobe
//   BLOCK_BYTES      : bytes moved by one instruction
package ub_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2,
        OP_EXT   = 2'd3
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE_WAIT,
        ST_EXT_ISSUE,
        ST_EXT_DRAIN
    } ctrl_state_t;

    localparam int unsigned EXT_DRAIN_CYCLES = 5;
    localparam int unsigned BLOCK_BYTES      = 4;

endpackage

// File: rtl/ub_controller.sv
// ub_controller
//   Sequencer owning the unified buffer control pins. Accepts one instruction
//   at a time, drives address and one-hot strobes, waits on accumulator full
//   flags (with timeout) for STORE, and signals completion and errors.
//
//   clk, reset          : clock, asynchronous active-high reset
//   instr_valid/ready   : instruction handshake (ready only in IDLE)
//   instr_op            : 0 NOP, 1 LOAD, 2 STORE, 3 EXT
//   instr_addr          : base byte address of the 4-byte block
//   full_acc1/2         : accumulator full flags
//   ub_addr             : buffer address (held until next accept)
//   ub_load_input/store/ext : buffer strobes, at most one high
//   host_valid          : buffer final_out carries host data this cycle
//   busy                : state is not IDLE
//   done                : one-cycle retire pulse
//   err_addr/err_timeout: one-cycle error pulses, coincident with done
module ub_controller
    import ub_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 13,
    parameter int unsigned MEM_SIZE = 32,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [1:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic              full_acc1,
    input  logic              full_acc2,
    output logic [ADDR_W-1:0] ub_addr,
    output logic              ub_load_input,
    output logic              ub_store,
    output logic              ub_ext,
    output logic              host_valid,
    output logic              busy,
    output logic              done,
    output logic              err_addr,
    output logic              err_timeout
);

    // Shared timeout/drain counter; must also reach EXT_DRAIN_CYCLES-1.
    localparam int unsigned CNT_W = ($clog2(WAIT_MAX + 1) > 3) ? $clog2(WAIT_MAX + 1) : 3;

    localparam logic [CNT_W-1:0]  WAIT_LAST  = CNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(EXT_DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DRAIN_DATA = CNT_W'(BLOCK_BYTES);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_SIZE - BLOCK_BYTES);

    ctrl_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_q, load_d;
    logic              store_q, store_d;
    logic              ext_q, ext_d;
    logic              hv_q, hv_d;
    logic              done_q, done_d;
    logic              erra_q, erra_d;
    logic              errt_q, errt_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        load_d  = 1'b0;
        store_d = 1'b0;
        ext_d   = 1'b0;
        hv_d    = 1'b0;
        done_d  = 1'b0;
        erra_d  = 1'b0;
        errt_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    addr_d = instr_addr;
                    if (instr_addr > ADDR_LIMIT) begin
                        done_d = 1'b1;
                        erra_d = 1'b1;
                    end else begin
                        case (opcode_t'(instr_op))
                            OP_NOP: done_d = 1'b1;
                            OP_LOAD: begin
                                state_d = ST_LOAD;
                                load_d  = 1'b1;
                            end
                            OP_STORE: begin
                                state_d = ST_STORE_WAIT;
                                store_d = 1'b1;
                                cnt_d   = '0;
                            end
                            OP_EXT: begin
                                state_d = ST_EXT_ISSUE;
                                ext_d   = 1'b1;
                            end
                            default: state_d = ST_IDLE;
                        endcase
                    end
                end
            end

            ST_LOAD: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end

            // Flags win over a timeout landing on the same edge.
            ST_STORE_WAIT: begin
                if (full_acc1 && full_acc2) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    errt_d  = 1'b1;
                end else begin
                    store_d = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            ST_EXT_ISSUE: begin
                state_d = ST_EXT_DRAIN;
                cnt_d   = '0;
            end

            // First BLOCK_BYTES drain cycles produce host data one cycle later.
            ST_EXT_DRAIN: begin
                hv_d = (cnt_q < DRAIN_DATA);
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            ext_q   <= 1'b0;
            hv_q    <= 1'b0;
            done_q  <= 1'b0;
            erra_q  <= 1'b0;
            errt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            store_q <= store_d;
            ext_q   <= ext_d;
            hv_q    <= hv_d;
            done_q  <= done_d;
            erra_q  <= erra_d;
            errt_q  <= errt_d;
        end
    end

    assign instr_ready   = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign ub_addr       = addr_q;
    assign ub_load_input = load_q;
    assign ub_store      = store_q;
    assign ub_ext        = ext_q;
    assign host_valid    = hv_q;
    assign done          = done_q;
    assign err_addr      = erra_q;
    assign err_timeout   = errt_q;

endmodule

// File: tb/tb_ub_controller.sv
// tb_ub_controller
//   Directed bench for ub_controller (MEM_SIZE=32, WAIT_MAX=4). Inputs are
//   driven and outputs sampled 1 time unit after each rising edge, so each
//   sample shows the cycle that follows that edge.
//   Status vector bit order: {load, store, ext, host_valid, done,
//   err_addr, err_timeout, busy}.
module tb_ub_controller;

    localparam int unsigned ADDR_W = 13;

    logic              clk = 1'b0;
    logic              reset;
    logic              instr_valid;
    logic              instr_ready;
    logic [1:0]        instr_op;
    logic [ADDR_W-1:0] instr_addr;
    logic              full_acc1;
    logic              full_acc2;
    logic [ADDR_W-1:0] ub_addr;
    logic              ub_load_input;
    logic              ub_store;
    logic              ub_ext;
    logic              host_valid;
    logic              busy;
    logic              done;
    logic              err_addr;
    logic              err_timeout;

    int checks = 0;
    int errors = 0;
    int writes = 0;

    always #5 clk = ~clk;

    ub_controller #(
        .ADDR_W  (ADDR_W),
        .MEM_SIZE(32),
        .WAIT_MAX(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_addr   (instr_addr),
        .full_acc1    (full_acc1),
        .full_acc2    (full_acc2),
        .ub_addr      (ub_addr),
        .ub_load_input(ub_load_input),
        .ub_store     (ub_store),
        .ub_ext       (ub_ext),
        .host_valid   (host_valid),
        .busy         (busy),
        .done         (done),
        .err_addr     (err_addr),
        .err_timeout  (err_timeout)
    );

    // Buffer write condition: store strobe with both flags at an edge.
    always @(posedge clk) begin
        if (ub_store && full_acc1 && full_acc2)
            writes <= writes + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_st(input string tag, input logic [7:0] exp);
        check(tag, {24'd0, ub_load_input, ub_store, ub_ext, host_valid,
                    done, err_addr, err_timeout, busy}, {24'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] op, input logic [ADDR_W-1:0] addr);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_addr  = addr;
    endtask

    // Accept at the next edge; returns positioned in c1.
    task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] addr);
        offer(op, addr);
        tick();
        instr_valid = 1'b0;
    endtask

    // Walks c1..c7 of an EXT already offered; optionally offers the next EXT in c7.
    task automatic ext_seq(input string tag, input logic [ADDR_W-1:0] addr,
                           input bit chain, input logic [ADDR_W-1:0] next_addr);
        logic [7:0] exp;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) begin
                instr_valid = 1'b0;
                check({tag, "_addr"}, 32'(ub_addr), 32'(addr));
            end
            exp = {1'b0, 1'b0, (k == 1), (k >= 3 && k <= 6), (k == 7), 1'b0, 1'b0, (k <= 6)};
            expect_st($sformatf("%s_c%0d", tag, k), exp);
            if (k == 7) begin
                check({tag, "_rdy"}, 32'(instr_ready), 32'd1);
                if (chain)
                    offer(2'd3, next_addr);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr_op    = 2'd0;
        instr_addr  = '0;
        full_acc1   = 1'b0;
        full_acc2   = 1'b0;

        // Reset state
        tick();
        tick();
        expect_st("rst_st", 8'b0000_0000);
        check("rst_addr", 32'(ub_addr), 32'd0);
        check("rst_rdy", 32'(instr_ready), 32'd1);
        reset = 1'b0;
        tick();

        // LOAD addr 4
        issue(2'd1, 13'd4);
        expect_st("ld_c1", 8'b1000_0001);
        check("ld_addr", 32'(ub_addr), 32'd4);
        check("ld_rdy_c1", 32'(instr_ready), 32'd0);
        tick();
        expect_st("ld_c2", 8'b0000_1000);
        check("ld_rdy_c2", 32'(instr_ready), 32'd1);
        tick();
        expect_st("ld_c3", 8'b0000_0000);

        // STORE addr 8, flags raised in c3
        issue(2'd2, 13'd8);
        expect_st("st_c1", 8'b0100_0001);
        tick();
        expect_st("st_c2", 8'b0100_0001);
        tick();
        full_acc1 = 1'b1;
        full_acc2 = 1'b1;
        expect_st("st_c3", 8'b0100_0001);
        tick();
        full_acc1 = 1'b0;
        full_acc2 = 1'b0;
        expect_st("st_c4", 8'b0000_1000);
        check("st_writes", 32'(writes), 32'd1);
        check("st_addr", 32'(ub_addr), 32'd8);

        // STORE addr 12, flags low -> timeout after 4 wait cycles
        issue(2'd2, 13'd12);
        expect_st("to_c1", 8'b0100_0001);
        for (int k = 2; k <= 4; k++) begin
            tick();
            expect_st($sformatf("to_c%0d", k), 8'b0100_0001);
        end
        tick();
        expect_st("to_c5", 8'b0000_1010);
        check("to_writes", 32'(writes), 32'd1);

        // Flags arrive on the timeout edge -> success
        issue(2'd2, 13'd16);
        tick();
        tick();
        tick();
        expect_st("co_c4", 8'b0100_0001);
        full_acc1 = 1'b1;
        full_acc2 = 1'b1;
        tick();
        full_acc1 = 1'b0;
        full_acc2 = 1'b0;
        expect_st("co_c5", 8'b0000_1000);
        check("co_writes", 32'(writes), 32'd2);

        // Flags already high -> minimum 2-cycle latency
        full_acc1 = 1'b1;
        full_acc2 = 1'b1;
        issue(2'd2, 13'd20);
        expect_st("mn_c1", 8'b0100_0001);
        tick();
        full_acc1 = 1'b0;
        full_acc2 = 1'b0;
        expect_st("mn_c2", 8'b0000_1000);
        check("mn_writes", 32'(writes), 32'd3);

        // EXT addr 0, then back-to-back EXT addr 4 accepted in c7
        offer(2'd3, 13'd0);
        ext_seq("ext0", 13'd0, 1'b1, 13'd4);
        ext_seq("ext4", 13'd4, 1'b0, 13'd0);
        tick();
        expect_st("ext_idle", 8'b0000_0000);

        // Address range: 29 rejected, 28 accepted
        issue(2'd1, 13'd29);
        expect_st("ae29", 8'b0000_1100);
        check("ae29_rdy", 32'(instr_ready), 32'd1);
        issue(2'd1, 13'd28);
        expect_st("a28_c1", 8'b1000_0001);
        tick();
        expect_st("a28_c2", 8'b0000_1000);

        // NOP: range-checked, otherwise a bare done
        issue(2'd0, 13'd30);
        expect_st("nop_bad", 8'b0000_1100);
        issue(2'd0, 13'd0);
        expect_st("nop_ok", 8'b0000_1000);
        tick();

        // Reset asserted during EXT_DRAIN
        issue(2'd3, 13'd8);
        tick();
        tick();
        expect_st("rd_c3", 8'b0001_0001);
        reset = 1'b1;
        #1;
        expect_st("rd_rst", 8'b0000_0000);
        check("rd_rdy", 32'(instr_ready), 32'd1);
        check("rd_addr", 32'(ub_addr), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        expect_st("rd_nodone", 8'b0000_0000);
        issue(2'd1, 13'd4);
        expect_st("rd_ld_c1", 8'b1000_0001);
        tick();
        expect_st("rd_ld_c2", 8'b0000_1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
